uart_calc_cmd_parser: RTL and testbench

//  Sits directly downstream of the UART receiver in the FPGA calculator. Consumes its

---
 rtl/calc_pkg.sv | 29 ++
 rtl/uart_calc_cmd_parser_if.sv | 15 +
 rtl/ascii_hex_decode.sv | 41 ++++
 rtl/uart_calc_cmd_parser.sv | 153 +++++++++++++++
 tb/tb_uart_calc_cmd_parser.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and ASCII constants for the calculator command parser.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_AND = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_A_FIRST,
        ST_A,
        ST_B_FIRST,
        ST_B,
        ST_HOLD
    } state_t;

    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_ESC    = 8'h1B;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_EQUALS = 8'h3D;
    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_MINUS  = 8'h2D;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_AMP    = 8'h26;

endpackage

// File: rtl/uart_calc_cmd_parser_if.sv
// Command handshake from the parser (master) to the ALU stage (slave).
interface uart_calc_cmd_parser_if
    import calc_pkg::*;
#(
    parameter int OPERAND_WIDTH = 16
) ();
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [OPERAND_WIDTH-1:0] cmd_a;
    logic [OPERAND_WIDTH-1:0] cmd_b;
    op_t                      cmd_op;

    modport master (output cmd_valid, output cmd_a, output cmd_b, output cmd_op, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_a, input cmd_b, input cmd_op, output cmd_ready);
endinterface

// File: rtl/ascii_hex_decode.sv
// Combinational classifier for one received ASCII byte.
module ascii_hex_decode
    import calc_pkg::*;
(
    input  logic [7:0] byte_data,
    output logic       is_digit,
    output logic [3:0] nibble,
    output logic       is_op,
    output op_t        op,
    output logic       is_term,
    output logic       is_space,
    output logic       is_esc
);
    always_comb begin
        is_digit = 1'b0;
        nibble   = 4'd0;
        is_op    = 1'b0;
        op       = OP_ADD;
        is_term  = (byte_data == ASCII_CR) || (byte_data == ASCII_EQUALS);
        // LF is swallowed like space so CR-LF line endings are harmless
        is_space = (byte_data == ASCII_SPACE) || (byte_data == ASCII_LF);
        is_esc   = (byte_data == ASCII_ESC);

        if (byte_data >= 8'h30 && byte_data <= 8'h39) begin
            is_digit = 1'b1;
            nibble   = byte_data[3:0];
        end else if ((byte_data >= 8'h41 && byte_data <= 8'h46) ||
                     (byte_data >= 8'h61 && byte_data <= 8'h66)) begin
            is_digit = 1'b1;
            nibble   = byte_data[3:0] + 4'd9;
        end

        case (byte_data)
            ASCII_PLUS:  begin is_op = 1'b1; op = OP_ADD; end
            ASCII_MINUS: begin is_op = 1'b1; op = OP_SUB; end
            ASCII_STAR:  begin is_op = 1'b1; op = OP_MUL; end
            ASCII_AMP:   begin is_op = 1'b1; op = OP_AND; end
            default:     ;
        endcase
    end
endmodule

// File: rtl/uart_calc_cmd_parser.sv
// Parses "<hexA><op><hexB><term>" from the UART byte stream into one command
// and holds it on a valid/ready handshake until the ALU stage accepts it.
module uart_calc_cmd_parser
    import calc_pkg::*;
#(
    parameter int OPERAND_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [7:0]            byte_data,
    input  logic                  byte_ready,
    uart_calc_cmd_parser_if.master cmd,
    output logic                  err_syntax,
    output logic                  err_overrun
);
    localparam int N  = OPERAND_WIDTH / 4;
    localparam int CW = $clog2(N + 1);

    logic       is_digit, is_op, is_term, is_space, is_esc;
    logic [3:0] nibble;
    op_t        dec_op;

    ascii_hex_decode u_decode (
        .byte_data (byte_data),
        .is_digit  (is_digit),
        .nibble    (nibble),
        .is_op     (is_op),
        .op        (dec_op),
        .is_term   (is_term),
        .is_space  (is_space),
        .is_esc    (is_esc)
    );

    state_t                   state_reg, state_next;
    logic [OPERAND_WIDTH-1:0] acc_a_reg, acc_a_next, acc_b_reg, acc_b_next;
    logic [CW-1:0]            cnt_reg, cnt_next;
    op_t                      op_reg, op_next;
    logic [OPERAND_WIDTH-1:0] cmd_a_reg, cmd_a_next, cmd_b_reg, cmd_b_next;
    op_t                      cmd_op_reg, cmd_op_next;
    logic                     err_syntax_reg, err_syntax_next;
    logic                     err_overrun_reg, err_overrun_next;
    logic                     restart;
    logic                     room;

    assign room = (cnt_reg < CW'(N));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg       <= ST_A_FIRST;
            acc_a_reg       <= '0;
            acc_b_reg       <= '0;
            cnt_reg         <= '0;
            op_reg          <= OP_ADD;
            cmd_a_reg       <= '0;
            cmd_b_reg       <= '0;
            cmd_op_reg      <= OP_ADD;
            err_syntax_reg  <= 1'b0;
            err_overrun_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            acc_a_reg       <= acc_a_next;
            acc_b_reg       <= acc_b_next;
            cnt_reg         <= cnt_next;
            op_reg          <= op_next;
            cmd_a_reg       <= cmd_a_next;
            cmd_b_reg       <= cmd_b_next;
            cmd_op_reg      <= cmd_op_next;
            err_syntax_reg  <= err_syntax_next;
            err_overrun_reg <= err_overrun_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        acc_a_next       = acc_a_reg;
        acc_b_next       = acc_b_reg;
        cnt_next         = cnt_reg;
        op_next          = op_reg;
        cmd_a_next       = cmd_a_reg;
        cmd_b_next       = cmd_b_reg;
        cmd_op_next      = cmd_op_reg;
        err_syntax_next  = 1'b0;
        err_overrun_next = 1'b0;
        restart          = 1'b0;

        if (state_reg == ST_HOLD) begin
            // Nothing is buffered while holding, even on the accepting cycle
            if (byte_ready)
                err_overrun_next = 1'b1;
            if (cmd.cmd_ready)
                restart = 1'b1;
        end else if (byte_ready && !is_space) begin
            if (is_esc) begin
                restart = 1'b1;
            end else begin
                case (state_reg)
                    ST_A_FIRST, ST_B_FIRST: begin
                        if (is_digit) begin
                            cnt_next   = CW'(1);
                            state_next = (state_reg == ST_A_FIRST) ? ST_A : ST_B;
                            if (state_reg == ST_A_FIRST)
                                acc_a_next = OPERAND_WIDTH'(nibble);
                            else
                                acc_b_next = OPERAND_WIDTH'(nibble);
                        end else begin
                            err_syntax_next = 1'b1;
                        end
                    end
                    ST_A: begin
                        if (is_digit && room) begin
                            acc_a_next = {acc_a_reg[OPERAND_WIDTH-5:0], nibble};
                            cnt_next   = cnt_reg + CW'(1);
                        end else if (is_op) begin
                            op_next    = dec_op;
                            cnt_next   = '0;
                            state_next = ST_B_FIRST;
                        end else begin
                            err_syntax_next = 1'b1;
                        end
                    end
                    ST_B: begin
                        if (is_digit && room) begin
                            acc_b_next = {acc_b_reg[OPERAND_WIDTH-5:0], nibble};
                            cnt_next   = cnt_reg + CW'(1);
                        end else if (is_term) begin
                            cmd_a_next  = acc_a_reg;
                            cmd_b_next  = acc_b_reg;
                            cmd_op_next = op_reg;
                            state_next  = ST_HOLD;
                        end else begin
                            err_syntax_next = 1'b1;
                        end
                    end
                    default: err_syntax_next = 1'b1;
                endcase
            end
        end

        if (restart || err_syntax_next) begin
            state_next = ST_A_FIRST;
            acc_a_next = '0;
            acc_b_next = '0;
            cnt_next   = '0;
        end
    end

    assign cmd.cmd_valid = (state_reg == ST_HOLD);
    assign cmd.cmd_a     = cmd_a_reg;
    assign cmd.cmd_b     = cmd_b_reg;
    assign cmd.cmd_op    = cmd_op_reg;
    assign err_syntax    = err_syntax_reg;
    assign err_overrun   = err_overrun_reg;
endmodule

// File: tb/tb_uart_calc_cmd_parser.sv
// Directed bench for the UART calculator command parser.
module tb_uart_calc_cmd_parser;
    import calc_pkg::*;

    logic       clock;
    logic       reset_n;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       err_syntax;
    logic       err_overrun;

    uart_calc_cmd_parser_if #(.OPERAND_WIDTH(16)) cmd_bus ();

    uart_calc_cmd_parser #(.OPERAND_WIDTH(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .cmd         (cmd_bus),
        .err_syntax  (err_syntax),
        .err_overrun (err_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Event log filled on the falling edge, read by the stimulus process
    int          syn_count   = 0;
    int          ovr_count   = 0;
    int          valid_count = 0;
    int          acc_count   = 0;
    logic [15:0] log_a  [64];
    logic [15:0] log_b  [64];
    logic [1:0]  log_op [64];

    always @(negedge clock) begin
        if (reset_n) begin
            syn_count   = syn_count + int'(err_syntax);
            ovr_count   = ovr_count + int'(err_overrun);
            valid_count = valid_count + int'(cmd_bus.cmd_valid);
            if (cmd_bus.cmd_valid && cmd_bus.cmd_ready && acc_count < 64) begin
                log_a[acc_count]  = cmd_bus.cmd_a;
                log_b[acc_count]  = cmd_bus.cmd_b;
                log_op[acc_count] = cmd_bus.cmd_op;
                acc_count = acc_count + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int rd_ptr = 0;

    task automatic check_cmd(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                             input logic [1:0] eop);
        check_eq({tag, "_count"}, 32'(acc_count - rd_ptr), 32'd1);
        if (acc_count > rd_ptr) begin
            check_eq({tag, "_a"},  32'(log_a[rd_ptr]),  32'(ea));
            check_eq({tag, "_b"},  32'(log_b[rd_ptr]),  32'(eb));
            check_eq({tag, "_op"}, 32'(log_op[rd_ptr]), 32'(eop));
            rd_ptr = acc_count;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_data  = b;
        byte_ready = 1'b1;
        @(posedge clock); #1;
        byte_ready = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int syn_base, ovr_base, vc_base;

    initial begin
        reset_n = 1'b0; byte_data = 8'h00; byte_ready = 1'b0; cmd_bus.cmd_ready = 1'b0;
        idle(3);
        check_eq("rst_valid", 32'(cmd_bus.cmd_valid), 32'd0);
        check_eq("rst_a", 32'(cmd_bus.cmd_a), 32'd0);
        check_eq("rst_b", 32'(cmd_bus.cmd_b), 32'd0);
        check_eq("rst_op", 32'(cmd_bus.cmd_op), 32'd0);
        check_eq("rst_err", 32'({err_syntax, err_overrun}), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // 1: simple add, ready always high
        cmd_bus.cmd_ready = 1'b1;
        syn_base = syn_count; ovr_base = ovr_count; vc_base = valid_count;
        send_str("12+3\r");
        check_eq("t1_latency", 32'(cmd_bus.cmd_valid), 32'd1);
        idle(3);
        check_cmd("t1", 16'h0012, 16'h0003, 2'(OP_ADD));
        check_eq("t1_valid_cycles", 32'(valid_count - vc_base), 32'd1);
        check_eq("t1_errs", 32'(syn_count - syn_base + ovr_count - ovr_base), 32'd0);
        $display("t1 \"12+3\\r\" done");

        // 2: mixed-case hex, '=' terminator, back-pressure
        cmd_bus.cmd_ready = 1'b0;
        vc_base = valid_count;
        send_str("fF*a0=");
        idle(20);
        check_eq("t2_held_valid", 32'(cmd_bus.cmd_valid), 32'd1);
        check_eq("t2_held_cycles", 32'(valid_count - vc_base >= 20), 32'd1);
        check_eq("t2_hold_a", 32'(cmd_bus.cmd_a), 32'h00FF);
        cmd_bus.cmd_ready = 1'b1;
        idle(1);
        check_eq("t2_dropped", 32'(cmd_bus.cmd_valid), 32'd0);
        check_cmd("t2", 16'h00FF, 16'h00A0, 2'(OP_MUL));
        $display("t2 \"fF*a0=\" done");

        // 3: five-digit operand overflows
        syn_base = syn_count; vc_base = valid_count;
        send_str("12345+1\r");
        idle(3);
        check_eq("t3_syntax", 32'(syn_count - syn_base), 32'd3);
        check_eq("t3_no_valid", 32'(valid_count - vc_base), 32'd0);
        $display("t3 \"12345+1\\r\" done");

        // 4: leading operator, then spaced command
        syn_base = syn_count;
        send_str("-5\r");
        idle(2);
        check_eq("t4_syntax", 32'(syn_count - syn_base), 32'd2);
        send_str("1 + 2\r");
        idle(3);
        check_cmd("t4", 16'h0001, 16'h0002, 2'(OP_ADD));
        check_eq("t4_syntax_after", 32'(syn_count - syn_base), 32'd2);
        $display("t4 \"-5\\r\" / \"1 + 2\\r\" done");

        // 5: overrun while holding, including on the accepting cycle
        cmd_bus.cmd_ready = 1'b0;
        ovr_base = ovr_count;
        send_str("7-2\r");
        idle(2);
        send_byte("x");
        idle(2);
        check_eq("t5_overrun", 32'(ovr_count - ovr_base), 32'd1);
        check_eq("t5_hold_valid", 32'(cmd_bus.cmd_valid), 32'd1);
        check_eq("t5_hold_a", 32'(cmd_bus.cmd_a), 32'h0007);
        check_eq("t5_hold_b", 32'(cmd_bus.cmd_b), 32'h0002);
        check_eq("t5_hold_op", 32'(cmd_bus.cmd_op), 32'(OP_SUB));
        byte_data = "y"; byte_ready = 1'b1; cmd_bus.cmd_ready = 1'b1;
        @(posedge clock); #1;
        byte_ready = 1'b0;
        idle(2);
        check_eq("t5_overrun_accept", 32'(ovr_count - ovr_base), 32'd2);
        check_cmd("t5_first", 16'h0007, 16'h0002, 2'(OP_SUB));
        send_str("3&1\r");
        idle(3);
        check_cmd("t5_and", 16'h0003, 16'h0001, 2'(OP_AND));
        $display("t5 overrun/AND done");

        // 6: escape aborts silently
        syn_base = syn_count;
        send_str("AB-");
        send_byte(8'h1B);
        send_str("1-1\r");
        idle(3);
        check_eq("t6_syntax", 32'(syn_count - syn_base), 32'd0);
        check_cmd("t6", 16'h0001, 16'h0001, 2'(OP_SUB));
        $display("t6 ESC abort done");

        // 7: full-width operands and B overflow
        send_str("FFFF*1234\r");
        idle(3);
        check_cmd("t7_full", 16'hFFFF, 16'h1234, 2'(OP_MUL));
        syn_base = syn_count;
        send_str("1+12345\r");
        idle(3);
        check_eq("t7_b_overflow", 32'(syn_count - syn_base), 32'd2);
        $display("t7 boundary widths done");

        // 8: reset mid-operand
        send_str("5A");
        reset_n = 1'b0;
        idle(1);
        check_eq("t8_rst_a", 32'(cmd_bus.cmd_a), 32'd0);
        check_eq("t8_rst_b", 32'(cmd_bus.cmd_b), 32'd0);
        check_eq("t8_rst_op", 32'(cmd_bus.cmd_op), 32'd0);
        check_eq("t8_rst_valid", 32'(cmd_bus.cmd_valid), 32'd0);
        reset_n = 1'b1;
        idle(1);
        syn_base = syn_count;
        send_str("9+8\r");
        idle(3);
        check_cmd("t8", 16'h0009, 16'h0008, 2'(OP_ADD));
        check_eq("t8_syntax", 32'(syn_count - syn_base), 32'd0);
        $display("t8 mid-operand reset done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
